// File: rtl/core_load_sequencer.sv
// rtl/core_load_sequencer.sv - command-driven SRAM-to-L0/IFIFO load sequencer
module core_load_sequencer #(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [addr_w-1:0]   act_base,
  input  logic [addr_w-1:0]   wt_base,
  input  logic [len_w-1:0]    act_len,
  input  logic [len_w-1:0]    wt_len,
  output logic                busy,
  output logic                done,
  output logic                xmem_cen,
  output logic                pmem_cen,
  output logic [addr_w-1:0]   xmem_a,
  output logic [addr_w-1:0]   pmem_a,
  input  logic [bw*row-1:0]   Q_act,
  input  logic [bw*col-1:0]   Q_wt,
  output logic [bw*row-1:0]   l0_in,
  output logic                l0_wr,
  input  logic                l0_full,
  output logic [bw*col-1:0]   ififo_in,
  output logic                ififo_wr,
  input  logic                ififo_full
);

  localparam int LW = bw * row;
  localparam int FW = bw * col;

  typedef enum logic [2:0] {
    S_IDLE, S_WS_WT, S_WS_ACT, S_OS_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [len_w-1:0]    idx_q, idx_d;
  logic                mode_q;
  logic [addr_w-1:0]   act_base_q, wt_base_q;
  logic [len_w-1:0]    act_len_q, wt_len_q;
  logic                inflight_q, src_wt_q;
  logic                skid_v_q;
  logic [LW-1:0]       l0_skid_q;
  logic [FW-1:0]       ff_skid_q;
  logic [addr_w-1:0]   xa_q, pa_q;

  logic                os_mode, dest_full, have_word, wr_now;
  logic                issue, last_issue, x_issue, p_issue;
  logic [len_w-1:0]    cur_len;
  logic [addr_w-1:0]   x_addr, p_addr;
  logic [LW-1:0]       ret_l0;

  // Datapath: issue gating, address generation and write-back selection
  always_comb begin
    os_mode    = ~mode_q;
    dest_full  = l0_full | (os_mode & ififo_full);
    have_word  = inflight_q | skid_v_q;
    wr_now     = have_word & ~dest_full;
    cur_len    = (state_q == S_WS_WT) ? wt_len_q : act_len_q;
    issue      = (state_q inside {S_WS_WT, S_WS_ACT, S_OS_STREAM}) & ~dest_full & ~skid_v_q;
    last_issue = issue & (idx_q == cur_len - len_w'(1));
    x_issue    = issue & (state_q != S_WS_WT);
    p_issue    = issue & (state_q != S_WS_ACT);
    x_addr     = act_base_q + addr_w'(idx_q);
    p_addr     = wt_base_q + addr_w'(idx_q);
    // weight words share the L0 path in WS
    ret_l0     = src_wt_q ? LW'(Q_wt) : Q_act;
    l0_wr      = wr_now;
    ififo_wr   = wr_now & os_mode;
    l0_in      = skid_v_q ? l0_skid_q : (inflight_q ? ret_l0 : '0);
    ififo_in   = !os_mode ? '0 : (skid_v_q ? ff_skid_q : (inflight_q ? Q_wt : '0));
    xmem_cen   = ~x_issue;
    pmem_cen   = ~p_issue;
    xmem_a     = x_issue ? x_addr : xa_q;
    pmem_a     = p_issue ? p_addr : pa_q;
  end

  // Next-state, word index and status outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (mode) begin
            if (wt_len != '0)       state_d = S_WS_WT;
            else if (act_len != '0) state_d = S_WS_ACT;
            else                    state_d = S_DONE;
          end else begin
            state_d = (act_len != '0) ? S_OS_STREAM : S_DONE;
          end
        end
      end
      S_WS_WT: begin
        if (last_issue) begin
          idx_d   = '0;
          state_d = (act_len_q != '0) ? S_WS_ACT : S_DRAIN;
        end else if (issue) begin
          idx_d = idx_q + len_w'(1);
        end
      end
      S_WS_ACT, S_OS_STREAM: begin
        if (last_issue)  state_d = S_DRAIN;
        else if (issue)  idx_d = idx_q + len_w'(1);
      end
      // in-flight word and skid are never both occupied
      S_DRAIN: if (!have_word || !dest_full) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and command capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      act_base_q <= '0;
      wt_base_q  <= '0;
      act_len_q  <= '0;
      wt_len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && start) begin
        mode_q     <= mode;
        act_base_q <= act_base;
        wt_base_q  <= wt_base;
        act_len_q  <= act_len;
        wt_len_q   <= wt_len;
      end
    end
  end

  // In-flight tracking, held addresses and the one-entry skid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      src_wt_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      l0_skid_q  <= '0;
      ff_skid_q  <= '0;
      xa_q       <= '0;
      pa_q       <= '0;
    end else begin
      inflight_q <= issue;
      src_wt_q   <= (state_q == S_WS_WT);
      if (x_issue) xa_q <= x_addr;
      if (p_issue) pa_q <= p_addr;
      if (skid_v_q) begin
        if (!dest_full) skid_v_q <= 1'b0;
      end else if (inflight_q && dest_full) begin
        skid_v_q  <= 1'b1;
        l0_skid_q <= ret_l0;
        ff_skid_q <= Q_wt;
      end
    end
  end

endmodule

// File: tb/tb_core_load_sequencer.sv
// tb/tb_core_load_sequencer.sv - self-checking bench for core_load_sequencer
module tb_core_load_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [10:0] act_base = '0, wt_base = '0;
  logic [10:0] act_len = '0, wt_len = '0;
  logic        busy, done, xmem_cen, pmem_cen;
  logic [10:0] xmem_a, pmem_a;
  logic [31:0] Q_act = '0, Q_wt = '0;
  logic [31:0] l0_in, ififo_in;
  logic        l0_wr, ififo_wr;
  logic        l0_full = 1'b0, ififo_full = 1'b0;

  core_load_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .act_base(act_base), .wt_base(wt_base), .act_len(act_len), .wt_len(wt_len),
    .busy(busy), .done(done), .xmem_cen(xmem_cen), .pmem_cen(pmem_cen),
    .xmem_a(xmem_a), .pmem_a(pmem_a), .Q_act(Q_act), .Q_wt(Q_wt),
    .l0_in(l0_in), .l0_wr(l0_wr), .l0_full(l0_full),
    .ififo_in(ififo_in), .ififo_wr(ififo_wr), .ififo_full(ififo_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rel = 0;
  bit running = 0;
  bit cur_os = 0;
  int exp_done_g = 0;
  int done_cnt, wr_cnt, first_wr;
  logic [31:0] exp_l0[$];
  logic [31:0] exp_ff[$];
  logic [10:0] xaddr_log[$];

  function automatic logic [31:0] act_word(input logic [10:0] a);
    return 32'hA5A5_0000 | {21'b0, a};
  endfunction

  function automatic logic [31:0] wt_word(input logic [10:0] a);
    return 32'h3C3C_0000 | {21'b0, a};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, rel);
    end
  endfunction

  // 1-cycle-latency SRAMs with address-derived contents
  always @(posedge clk) begin
    if (!xmem_cen) Q_act <= act_word(xmem_a);
    if (!pmem_cen) Q_wt  <= wt_word(pmem_a);
  end

  // Expected write stream: WS = weights then activations on L0; OS = lockstep pairs
  task automatic build_model(input logic m, input logic [10:0] ab, input logic [10:0] wb,
                             input logic [10:0] al, input logic [10:0] wl);
    exp_l0.delete();
    exp_ff.delete();
    if (m) begin
      for (int i = 0; i < int'(wl); i++) exp_l0.push_back(wt_word(wb + 11'(i)));
      for (int i = 0; i < int'(al); i++) exp_l0.push_back(act_word(ab + 11'(i)));
    end else begin
      for (int i = 0; i < int'(al); i++) begin
        exp_l0.push_back(act_word(ab + 11'(i)));
        exp_ff.push_back(wt_word(wb + 11'(i)));
      end
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (running) begin
      chk("busy", busy, (rel >= 1 && rel <= exp_done_g));
      chk("done", done, (rel == exp_done_g));
      if (done) done_cnt++;
      chk("ififo_pairing", ififo_wr, cur_os ? l0_wr : 1'b0);
      if (!xmem_cen) xaddr_log.push_back(xmem_a);
      if (l0_wr) begin
        chk("wr_while_full", l0_full | ififo_full, 1'b0);
        if (first_wr < 0) first_wr = rel;
        wr_cnt++;
        if (exp_l0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write: got %0h expected no write (cycle %0d)", l0_in, rel);
        end else begin
          chk("l0_data", l0_in, exp_l0.pop_front());
          if (cur_os) chk("ififo_data", ififo_in, exp_ff.pop_front());
        end
      end
    end
  end

  task automatic run_cmd(input logic m, input logic [10:0] ab, input logic [10:0] wb,
                         input logic [10:0] al, input logic [10:0] wl,
                         input int stall_lo, input int stall_hi, input int exp_done, input int ign_at);
    int n;
    build_model(m, ab, wb, al, wl);
    n = exp_l0.size();
    exp_done_g = exp_done;
    cur_os = !m;
    done_cnt = 0;
    wr_cnt = 0;
    first_wr = -1;
    xaddr_log.delete();
    @(posedge clk); #1;
    start = 1'b1; mode = m; act_base = ab; wt_base = wb; act_len = al; wt_len = wl;
    rel = 0;
    running = 1;
    for (int c = 1; c <= exp_done + 2; c++) begin
      @(posedge clk); #1;
      rel = c;
      if (c == ign_at) begin
        start = 1'b1; mode = !m; act_base = 11'h555; wt_base = 11'h2AA;
        act_len = 11'd3; wt_len = 11'd3;
      end else begin
        start = 1'b0; mode = m; act_base = ab; wt_base = wb; act_len = al; wt_len = wl;
      end
      l0_full = (c >= stall_lo && c <= stall_hi);
    end
    @(negedge clk); #1;
    running = 0;
    chk("done_count", done_cnt, 1);
    chk("write_count", wr_cnt, n);
    if (stall_lo < 0 && n > 0) chk("first_write_cycle", first_wr, 2);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_xcen", xmem_cen, 1'b1);
    chk("rst_pcen", pmem_cen, 1'b1);
    chk("rst_l0_wr", l0_wr, 1'b0);
    chk("rst_ififo_wr", ififo_wr, 1'b0);
    chk("rst_l0_in", l0_in, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // pin the model with hand-computed words
    build_model(1'b1, 11'h100, 11'h010, 11'd16, 11'd8);
    chk("model_len", exp_l0.size(), 24);
    chk("model_first_wt", exp_l0[0], 32'h3C3C_0010);
    chk("model_first_act", exp_l0[8], 32'hA5A5_0100);
    chk("model_last_act", exp_l0[23], 32'hA5A5_010F);

    // WS: 8 weights then 16 activations, done in cycle 26
    run_cmd(1'b1, 11'h100, 11'h010, 11'd16, 11'd8, -1, -1, 26, 0);

    // OS: 4 lockstep pairs, wt_len ignored
    run_cmd(1'b0, 11'h020, 11'h040, 11'd4, 11'd7, -1, -1, 6, 0);

    // WS act-only with l0_full in cycles 4..6: four cycles later than unstalled (12)
    run_cmd(1'b1, 11'h180, 11'h000, 11'd10, 11'd0, 4, 6, 16, 0);

    // address wrap
    run_cmd(1'b1, 11'h7FE, 11'h000, 11'd4, 11'd0, -1, -1, 6, 0);
    chk("wrap_count", xaddr_log.size(), 4);
    if (xaddr_log.size() == 4) begin
      chk("wrap_a0", xaddr_log[0], 11'h7FE);
      chk("wrap_a1", xaddr_log[1], 11'h7FF);
      chk("wrap_a2", xaddr_log[2], 11'h000);
      chk("wrap_a3", xaddr_log[3], 11'h001);
    end

    // zero-length command: done in cycle 1, no writes
    run_cmd(1'b1, 11'h050, 11'h060, 11'd0, 11'd0, -1, -1, 1, 0);

    // start pulsed mid-transfer is ignored
    run_cmd(1'b1, 11'h300, 11'h000, 11'd8, 11'd0, -1, -1, 10, 3);

    // reset in cycle 5 of a 16-word transfer
    build_model(1'b1, 11'h200, 11'h000, 11'd16, 11'd0);
    exp_done_g = 18;
    cur_os = 0;
    done_cnt = 0;
    wr_cnt = 0;
    first_wr = -1;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; act_base = 11'h200; wt_base = 11'h000;
    act_len = 11'd16; wt_len = 11'd0;
    rel = 0;
    running = 1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      rel = c;
      start = 1'b0;
    end
    @(posedge clk); #1;
    rel = 5;
    running = 0;
    reset = 1'b0;
    #1;
    chk("prereset_writes", wr_cnt, 3);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_l0_wr", l0_wr, 1'b0);
    chk("mid_rst_ififo_wr", ififo_wr, 1'b0);
    chk("mid_rst_xcen", xmem_cen, 1'b1);
    chk("mid_rst_pcen", pmem_cen, 1'b1);
    chk("mid_rst_xa", xmem_a, 11'h000);
    chk("mid_rst_pa", pmem_a, 11'h000);
    chk("mid_rst_l0_in", l0_in, 32'h0);
    chk("mid_rst_ififo_in", ififo_in, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // fresh command after release runs from its own base
    run_cmd(1'b1, 11'h600, 11'h000, 11'd5, 11'd0, -1, -1, 7, 0);
    if (xaddr_log.size() > 0) chk("post_rst_first_addr", xaddr_log[0], 11'h600);
    else chk("post_rst_addr_count", xaddr_log.size(), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
